// File: rtl/activation_pkg.sv
// Shared types and sizes for the layer-3 ReLU activation block.
package activation_pkg;

    localparam int BITWIDTH = 32;
    localparam int NUM_ELEM = 10;

    typedef logic signed [BITWIDTH-1:0] act_t;
    typedef act_t act_vec_t [NUM_ELEM];

endpackage

// File: rtl/relu_unit.sv
// Combinational single-element rectifier; negative inputs are clamped to zero,
// or scaled by 1/8 when ACT_LEAKY_RELU_EN is defined.
module relu_unit
    import activation_pkg::*;
(
    input  act_t i_val,
    output act_t o_val,
    output logic o_clamp
);

    logic w_neg;

    // Only the sign bit decides; no arithmetic on the positive path.
    assign w_neg   = i_val[BITWIDTH-1];
    assign o_clamp = w_neg;

`ifdef ACT_LEAKY_RELU_EN
    assign o_val = w_neg ? act_t'(i_val >>> 3) : i_val;
`else
    assign o_val = w_neg ? act_t'('0) : i_val;
`endif

endmodule

// File: rtl/activation_layer_3.sv
// Registered element-wise ReLU for layer 3 (leaky variant under ACT_LEAKY_RELU_EN).
module activation_layer_3
    import activation_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    input  act_vec_t            featuremap,
    output logic                out_valid,
    output act_vec_t            featuremap_RELUed,
    output logic [NUM_ELEM-1:0] zero_mask
);

    act_vec_t            w_relu;
    logic [NUM_ELEM-1:0] w_clamp;

    act_vec_t            r_data;
    logic [NUM_ELEM-1:0] r_mask;
    logic                r_valid;

    for (genvar g = 0; g < NUM_ELEM; g++) begin : g_relu
        relu_unit u_relu (
            .i_val   (featuremap[g]),
            .o_val   (w_relu[g]),
            .o_clamp (w_clamp[g])
        );
    end

    // Handshake: a vector is taken on every rising edge with in_valid=1 (no ready,
    // no backpressure); out_valid pulses for exactly the cycle after each accept,
    // while data and mask hold their last result until the next accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_ELEM; i++) begin
                r_data[i] <= '0;
            end
            r_mask  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                for (int i = 0; i < NUM_ELEM; i++) begin
                    r_data[i] <= w_relu[i];
                end
                r_mask <= w_clamp;
            end
        end
    end

    assign featuremap_RELUed = r_data;
    assign zero_mask         = r_mask;
    assign out_valid         = r_valid;

endmodule

// File: tb/tb_activation_layer_3.sv
// Randomised self-checking bench for activation_layer_3 against an arithmetic ReLU model.
module tb_activation_layer_3;
    import activation_pkg::*;

    logic                clk;
    logic                rst_n;
    logic                in_valid;
    act_vec_t            featuremap;
    logic                out_valid;
    act_vec_t            featuremap_RELUed;
    logic [NUM_ELEM-1:0] zero_mask;

    int total;
    int bad;

    logic [BITWIDTH-1:0] exp_data [NUM_ELEM];
    logic [NUM_ELEM-1:0] exp_mask;
    logic                exp_valid;
    logic [NUM_ELEM-1:0] exp_q[$];

    activation_layer_3 dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .in_valid          (in_valid),
        .featuremap        (featuremap),
        .out_valid         (out_valid),
        .featuremap_RELUed (featuremap_RELUed),
        .zero_mask         (zero_mask)
    );

    // clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference: value as a mathematical integer; negatives -> 0, or floor(v/8) when leaky.
    function automatic logic [31:0] ref_act(input logic [31:0] x);
        longint v;
        longint q;
        v = longint'($signed(x));
        if (v >= 0) return x;
`ifdef ACT_LEAKY_RELU_EN
        q = -((-v + 7) / 8);
        return q[31:0];
`else
        q = 0;
        return q[31:0];
`endif
    endfunction

    function automatic logic [31:0] rand_word();
        case ($urandom_range(0, 7))
            0: return 32'h7FFF_FFFF;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'h0000_0000;
            4: return 32'($urandom_range(0, 2000)) - 32'd1000;
            default: return $urandom;
        endcase
    endfunction

    task automatic randomize_inputs();
        for (int i = 0; i < NUM_ELEM; i++) featuremap[i] = rand_word();
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_ELEM; i++) exp_data[i] = '0;
        exp_mask  = '0;
        exp_valid = 1'b0;
        exp_q.delete();
    endtask

    task automatic check_outputs(input string tag);
        logic [NUM_ELEM-1:0] m;
        for (int i = 0; i < NUM_ELEM; i++)
            check_eq($sformatf("%s_data%0d", tag, i), featuremap_RELUed[i], exp_data[i]);
        check_eq({tag, "_mask"}, 32'(zero_mask), 32'(exp_mask));
        check_eq({tag, "_valid"}, 32'(out_valid), 32'(exp_valid));
        if (out_valid === 1'b1) begin
            check_eq({tag, "_q_nonempty"}, 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                m = exp_q.pop_front();
                check_eq({tag, "_q_mask"}, 32'(zero_mask), 32'(m));
            end
        end
    endtask

    // Driver: inputs are set before the edge, model updated at the edge, DUT sampled at negedge.
    task automatic step(input logic v, input string tag);
        in_valid = v;
        @(posedge clk);
        if (rst_n) begin
            if (v) begin
                for (int i = 0; i < NUM_ELEM; i++) begin
                    exp_data[i] = ref_act(featuremap[i]);
                    exp_mask[i] = ($signed(featuremap[i]) < 0);
                end
                exp_q.push_back(exp_mask);
            end
            exp_valid = v;
        end
        @(negedge clk);
        check_outputs(tag);
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        rst_n    = 1'b0;
        in_valid = 1'b1;
        randomize_inputs();
        model_reset();

        // Reset held with live random inputs
        repeat (3) begin
            @(negedge clk);
            randomize_inputs();
            check_outputs("reset");
        end
        rst_n = 1'b1;
        in_valid = 1'b0;

        // Directed vector with one clamped element
        for (int i = 0; i < NUM_ELEM; i++) featuremap[i] = '0;
        featuremap[0] = 32'sd1;
        featuremap[1] = 32'sd2;
        featuremap[2] = 32'sd3;
        featuremap[3] = -32'sd1145;
        step(1'b1, "basic");
        check_eq("basic_mask_lit", 32'(zero_mask), 32'b0000001000);
        step(1'b0, "basic_drop");

        // Boundary values
        for (int i = 0; i < NUM_ELEM; i++) featuremap[i] = 32'sd7;
        featuremap[0] = 32'h7FFF_FFFF;
        featuremap[1] = 32'h8000_0000;
        featuremap[2] = 32'hFFFF_FFFF;
        step(1'b1, "bound");
        check_eq("bound_max", featuremap_RELUed[0], 32'h7FFF_FFFF);
`ifdef ACT_LEAKY_RELU_EN
        check_eq("bound_min", featuremap_RELUed[1], 32'hF000_0000);
        check_eq("bound_m1", featuremap_RELUed[2], 32'hFFFF_FFFF);
`else
        check_eq("bound_min", featuremap_RELUed[1], 32'h0);
        check_eq("bound_m1", featuremap_RELUed[2], 32'h0);
`endif

        // Hold: changed inputs with in_valid low must not disturb outputs
        randomize_inputs();
        step(1'b1, "hold_load");
        randomize_inputs();
        step(1'b0, "hold0");
        randomize_inputs();
        step(1'b0, "hold1");

        // Back-to-back accepts
        repeat (3) begin
            randomize_inputs();
            step(1'b1, "b2b");
        end
        step(1'b0, "b2b_end");

`ifdef ACT_LEAKY_RELU_EN
        for (int i = 0; i < NUM_ELEM; i++) featuremap[i] = '0;
        featuremap[0] = -32'sd1;
        featuremap[3] = -32'sd1145;
        step(1'b1, "leaky");
        check_eq("leaky_1145", featuremap_RELUed[3], 32'hFFFF_FF70);
        check_eq("leaky_m1", featuremap_RELUed[0], 32'hFFFF_FFFF);
        check_eq("leaky_mask", 32'(zero_mask), 32'b0000001001);
`endif

        // Randomised traffic
        for (int n = 0; n < 300; n++) begin
            randomize_inputs();
            step(1'($urandom_range(0, 2) != 0), "rand");
        end

        // Asynchronous reset mid-stream, between edges, discards the pending vector
        randomize_inputs();
        step(1'b1, "pre_rst");
        randomize_inputs();
        in_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("async_rst");
        @(posedge clk);
        @(negedge clk);
        check_outputs("rst_hold");
        rst_n = 1'b1;
        randomize_inputs();
        step(1'b1, "post_rst");
        step(1'b0, "post_rst_drop");

        check_eq("q_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
